// File: rtl/la_arb5rr.sv
// Five-way round-robin arbiter with registered one-hot grant, bounded hold time
// and a one-cycle timeout pulse when a hold is cut short.
module la_arb5rr #(
  parameter     PROP    = "DEFAULT",
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [4:0] req,
  output logic [4:0] gnt,
  output logic       busy,
  output logic [2:0] owner,
  output logic       tout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam logic [7:0] CNT_LIMIT  = 8'(TIMEOUT - 1);
  localparam bit         TIMEOUT_EN = (TIMEOUT != 0);

  // PROP is an implementation tag only; this empty block just references it.
  if (PROP == "") begin : g_empty_prop
  end

  logic [0:0] state;
  logic [2:0] ptr;
  logic [7:0] cnt;
  logic [2:0] sel;
  logic       found;
  logic [3:0] scan;
  logic [2:0] next_ptr;
  logic       release_hit;
  logic       timeout_hit;

  // First requester at or after ptr in circular order.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    scan  = '0;
    for (int unsigned k = 0; k < 5; k++) begin
      scan = {1'b0, ptr} + 4'(k);
      if (scan >= 4'd5) scan = scan - 4'd5;
      if (!found && req[scan[2:0]]) begin
        found = 1'b1;
        sel   = scan[2:0];
      end
    end
  end

  always_comb begin
    next_ptr    = (owner == 3'd4) ? '0 : owner + 3'd1;
    release_hit = !req[owner];
    timeout_hit = TIMEOUT_EN && (cnt == CNT_LIMIT);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state <= IDLE;
      gnt   <= '0;
      busy  <= 1'b0;
      owner <= '0;
      tout  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          tout <= 1'b0;
          cnt  <= '0;
          if (found) begin
            gnt   <= 5'b00001 << sel;
            busy  <= 1'b1;
            owner <= sel;
            state <= GRANT;
          end else begin
            gnt  <= '0;
            busy <= 1'b0;
          end
        end
        default: begin
          if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          // Release is checked first so it takes precedence over a coincident timeout.
          if (release_hit || timeout_hit) begin
            gnt   <= '0;
            busy  <= 1'b0;
            ptr   <= next_ptr;
            tout  <= !release_hit;
            state <= IDLE;
          end else begin
            tout <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_la_arb5rr.sv
// Self-checking bench for la_arb5rr: directed scenarios plus randomized traffic
// compared cycle by cycle against a behavioural holder/rotation model.
module tb_la_arb5rr;

  localparam int TO = 4;

  logic       clk;
  logic       nreset;
  logic [4:0] req;
  logic [4:0] gnt;
  logic       busy;
  logic [2:0] owner;
  logic       tout;

  int checks = 0;
  int errors = 0;

  // Reference model: who holds the grant, for how many cycles, and where the scan starts.
  int         m_holder;
  int         m_held;
  int         m_ptr;
  logic [4:0] m_gnt;
  logic       m_busy;
  logic [2:0] m_owner;
  logic       m_tout;

  la_arb5rr #(.PROP("DEFAULT"), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .nreset(nreset),
    .req   (req),
    .gnt   (gnt),
    .busy  (busy),
    .owner (owner),
    .tout  (tout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input logic [4:0] r, input logic n);
    req    = r;
    nreset = n;
    @(posedge clk);
    #1;
    if (!n) begin
      m_holder = -1; m_held = 0; m_ptr = 0;
      m_gnt = '0; m_busy = 1'b0; m_owner = '0; m_tout = 1'b0;
    end else if (m_holder < 0) begin
      m_tout = 1'b0;
      for (int k = 0; k < 5; k++)
        if (m_holder < 0 && r[(m_ptr + k) % 5]) m_holder = (m_ptr + k) % 5;
      if (m_holder >= 0) begin
        m_gnt = 5'(1 << m_holder); m_busy = 1'b1; m_owner = 3'(m_holder); m_held = 1;
      end else begin
        m_gnt = '0; m_busy = 1'b0;
      end
    end else if (!r[m_holder] || (TO != 0 && m_held == TO)) begin
      m_tout   = r[m_holder];
      m_ptr    = (m_holder + 1) % 5;
      m_holder = -1;
      m_gnt    = '0;
      m_busy   = 1'b0;
    end else begin
      m_held = m_held + 1;
      m_tout = 1'b0;
    end
  endtask

  task automatic test_reset();
    tick($urandom_range(31, 0), 1'b0);
    tick(5'b11111, 1'b0);
    checks++;
    if ({gnt, busy, owner, tout} !== 10'b0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b busy=%b owner=%0d tout=%b, need all zero", gnt, busy, owner, tout);
    end
  endtask

  task automatic test_rotation();
    tick(5'b00000, 1'b0);
    tick(5'b10100, 1'b1);
    checks++;
    if (gnt !== 5'b00100 || owner !== 3'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL first_grant: gnt=%b owner=%0d busy=%b, need 00100/2/1", gnt, owner, busy);
    end
    tick(5'b10000, 1'b1);
    checks++;
    if (gnt !== 5'b00000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL release_idle: gnt=%b busy=%b, need 00000/0", gnt, busy);
    end
    tick(5'b10000, 1'b1);
    checks++;
    if (gnt !== 5'b10000 || owner !== 3'd4) begin
      errors++;
      $display("FAIL grant_4: gnt=%b owner=%0d, need 10000/4", gnt, owner);
    end
    tick(5'b00000, 1'b1);
    tick(5'b11111, 1'b1);
    checks++;
    if (gnt !== 5'b00001 || owner !== 3'd0) begin
      errors++;
      $display("FAIL ptr_wrap: gnt=%b owner=%0d, need 00001/0", gnt, owner);
    end
  endtask

  task automatic test_timeout();
    tick(5'b00000, 1'b0);
    for (int c = 0; c < 4; c++) begin
      tick(5'b00001, 1'b1);
      checks++;
      if (gnt !== 5'b00001 || tout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_hold[%0d]: gnt=%b tout=%b, need 00001/0", c, gnt, tout);
      end
    end
    tick(5'b00001, 1'b1);
    checks++;
    if (gnt !== 5'b00000 || tout !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_revoke: gnt=%b tout=%b busy=%b, need 00000/1/0", gnt, tout, busy);
    end
    tick(5'b00001, 1'b1);
    checks++;
    if (gnt !== 5'b00001 || tout !== 1'b0 || owner !== 3'd0) begin
      errors++;
      $display("FAIL timeout_regrant: gnt=%b tout=%b owner=%0d, need 00001/0/0", gnt, tout, owner);
    end
  endtask

  task automatic test_release_at_limit();
    tick(5'b00000, 1'b0);
    for (int c = 0; c < 4; c++) tick(5'b00001, 1'b1);
    tick(5'b00000, 1'b1);
    checks++;
    if (gnt !== 5'b00000 || tout !== 1'b0) begin
      errors++;
      $display("FAIL release_wins: gnt=%b tout=%b, need 00000/0", gnt, tout);
    end
  endtask

  task automatic test_round_robin();
    tick(5'b00000, 1'b0);
    tick(5'b11111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (gnt !== 5'(1 << (i % 5)) || owner !== 3'(i % 5)) begin
        errors++;
        $display("FAIL rr_order[%0d]: gnt=%b owner=%0d, need owner %0d", i, gnt, owner, i % 5);
      end
      tick(5'b11111 & ~5'(1 << (i % 5)), 1'b1);
      checks++;
      if (gnt !== 5'b00000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rr_gap[%0d]: gnt=%b busy=%b, need 00000/0", i, gnt, busy);
      end
      tick(5'b11111, 1'b1);
    end
  endtask

  task automatic test_reset_mid_grant();
    tick(5'b00000, 1'b0);
    tick(5'b01000, 1'b1);
    tick(5'b01000, 1'b1);
    checks++;
    if (gnt !== 5'b01000 || owner !== 3'd3) begin
      errors++;
      $display("FAIL pre_reset_grant: gnt=%b owner=%0d, need 01000/3", gnt, owner);
    end
    tick(5'b01000, 1'b0);
    checks++;
    if (gnt !== 5'b00000 || owner !== 3'd0 || tout !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: gnt=%b owner=%0d tout=%b busy=%b, need 00000/0/0/0", gnt, owner, tout, busy);
    end
    tick(5'b11111, 1'b1);
    checks++;
    if (gnt !== 5'b00001 || owner !== 3'd0) begin
      errors++;
      $display("FAIL post_reset_grant: gnt=%b owner=%0d, need 00001/0", gnt, owner);
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    logic       n;
    r = '0;
    tick(5'b00000, 1'b0);
    for (int c = 0; c < 600; c++) begin
      // Requesters mostly hold their level; bits flip occasionally, reset is rare.
      for (int b = 0; b < 5; b++)
        if ($urandom_range(5, 0) == 0) r[b] = ~r[b];
      n = ($urandom_range(60, 0) != 0);
      tick(r, n);
      checks++;
      if (gnt !== m_gnt || busy !== m_busy || owner !== m_owner || tout !== m_tout) begin
        errors++;
        $display("FAIL random[%0d] req=%b nreset=%b: gnt=%b busy=%b owner=%0d tout=%b, need %b/%b/%0d/%b",
                 c, r, n, gnt, busy, owner, tout, m_gnt, m_busy, m_owner, m_tout);
      end
      checks++;
      if (!$onehot0(gnt) || ((gnt != 5'b0) !== busy)) begin
        errors++;
        $display("FAIL onehot_busy[%0d]: gnt=%b busy=%b, need one-hot-or-zero gnt matching busy", c, gnt, busy);
      end
    end
  endtask

  initial begin
    req    = '0;
    nreset = 1'b0;
    m_holder = -1; m_held = 0; m_ptr = 0;
    m_gnt = '0; m_busy = 1'b0; m_owner = '0; m_tout = 1'b0;
    test_reset();
    test_rotation();
    test_timeout();
    test_release_at_limit();
    test_round_robin();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
